display_scan_ctrl: RTL



---
 rtl/display_pkg.sv | 8 +
 rtl/display_if.sv | 23 ++
 rtl/tick_prescaler.sv | 18 +
 rtl/display_scan_ctrl.sv | 81 ++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared states and timing constants for the display scan controller
package display_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} state_t;
  localparam int SLOT_TICKS = 16;
  localparam int BLANK_TICKS = 1;
  localparam int BRIGHT_W = 4;
  localparam logic [6:0] SEG_OFF = 7'b0;
endpackage

// File: rtl/display_if.sv
// display_if: upstream control and display pin bundle of the scan controller
interface display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W = $clog2(NUM_DIGITS)
);
  import display_pkg::*;
  logic enable;
  logic [BRIGHT_W-1:0] brightness;
  logic [7*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [6:0] seg;
  logic [NUM_DIGITS-1:0] anode;
  logic [IDX_W-1:0] digit_idx;
  logic frame_start;
  modport master (
    output enable, brightness, digit_data, blank_mask,
    input seg, anode, digit_idx, frame_start
  );
  modport slave (
    input enable, brightness, digit_data, blank_mask,
    output seg, anode, digit_idx, frame_start
  );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick strobe every PRESCALE clocks, held cleared by clr
module tick_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [CW-1:0] cnt;
  assign tick = !clr && cnt == CW'(PRESCALE - 1);
  // Count 0..PRESCALE-1 and wrap on the tick
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: sequenced 7-segment scan with dead-time blank, PWM window and per-digit blanking
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE = 1000,
  parameter int IDX_W = $clog2(NUM_DIGITS)
) (
  input logic clk,
  input logic rst,
  display_if.slave bus
);
  state_t state, nxt;
  logic tick, blank_done, on_done, slot_done, enter;
  logic [BRIGHT_W-1:0] tick_cnt, bri_q;
  logic [IDX_W-1:0] idx_q, idx_nx;
  logic [6:0] pat_q, seg_q;
  logic mask_q, fs_q;
  logic [NUM_DIGITS-1:0] anode_q;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .tick(tick)
  );

  assign blank_done = tick && tick_cnt == BRIGHT_W'(BLANK_TICKS - 1);
  assign on_done = tick && tick_cnt == bri_q + BRIGHT_W'(BLANK_TICKS - 1);
  assign slot_done = tick && tick_cnt == BRIGHT_W'(SLOT_TICKS - 1);

  // Next state: advance on tick boundaries; losing enable always returns to IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = BLANK;
      BLANK: nxt = blank_done ? ((bri_q != '0 && !mask_q) ? ON : OFF) : BLANK;
      ON: nxt = on_done ? (slot_done ? BLANK : OFF) : ON;
      OFF: nxt = slot_done ? BLANK : OFF;
      default: nxt = IDLE;
    endcase
    if (!bus.enable) nxt = IDLE;
  end

  assign enter = nxt == BLANK && state != BLANK;
  assign idx_nx = (nxt == IDLE || state == IDLE) ? '0 :
                  !enter ? idx_q :
                  idx_q == IDX_W'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;

  // State, slot-entry latches and pin drive all update on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx_q <= '0;
      tick_cnt <= '0;
      pat_q <= SEG_OFF;
      bri_q <= '0;
      mask_q <= 1'b0;
      seg_q <= SEG_OFF;
      anode_q <= '0;
      fs_q <= 1'b0;
    end else begin
      state <= nxt;
      idx_q <= idx_nx;
      tick_cnt <= state == IDLE ? '0 : tick ? tick_cnt + 1'b1 : tick_cnt;
      if (enter) begin
        pat_q <= bus.digit_data[7*int'(idx_nx) +: 7];
        bri_q <= bus.brightness;
        mask_q <= bus.blank_mask[idx_nx];
      end
      seg_q <= nxt == ON ? pat_q : SEG_OFF;
      anode_q <= nxt == ON ? NUM_DIGITS'(1) << idx_q : '0;
      fs_q <= enter && idx_nx == '0;
    end
  end

  assign bus.seg = seg_q;
  assign bus.anode = anode_q;
  assign bus.digit_idx = idx_q;
  assign bus.frame_start = fs_q;
endmodule
